alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 32-bit logic unit and its arithmetic sibling.
- Each cycle it selects the result for the issued opcode class and computes status flags (zero, negative, carry, overflow, illegal-op).
- It presents result and flags to the consumer (register writeback / branch unit) over a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput under backpressure, and a free-running counter tracks completed results.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_skid_buf.sv | 73 +++++++
 rtl/alu_result_stage.sv | 92 +++++++++
 tb/tb_alu_result_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result stage: opcode classes,
// the stored result record and the zero/negative flag helper.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OP_W  = 4;

    // Opcode class lives in alu_op[3:2]; the remaining two encodings are illegal.
    localparam logic [1:0] CLS_LOGIC = 2'b00;
    localparam logic [1:0] CLS_ARITH = 2'b01;

    // One completed result together with everything the consumer needs.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_OP_W-1:0]  op;
        logic                 zero;
        logic                 neg;
        logic                 carry;
        logic                 ovf;
        logic                 err;
    } alu_res_t;

    typedef struct packed {
        logic zero;
        logic neg;
    } res_flags_t;

    // Zero and negative depend only on the selected result value.
    function automatic res_flags_t calcFlags(input logic [ALU_WIDTH-1:0] result);
        res_flags_t flags;
        flags.zero = (result == '0);
        flags.neg  = result[ALU_WIDTH-1];
        return flags;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The main entry drives the
// output; the skid entry catches the one transaction that can arrive while
// the main entry is stalled. inReady is a plain register (~skidValid), so
// there is no combinational path from outReady back to inReady.
module alu_skid_buf #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [PAYLOAD_W-1:0] inData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [PAYLOAD_W-1:0] outData
);

    logic                 mainValid;
    logic                 skidValid;
    logic [PAYLOAD_W-1:0] mainData;
    logic [PAYLOAD_W-1:0] skidData;

    logic inFire;
    logic outFire;
    logic mainFree;
    logic loadSkid;

    assign inFire   = inValid && !skidValid;
    assign outFire  = mainValid && outReady;
    // Main can take a new entry this cycle if it is empty or being popped.
    assign mainFree = !mainValid || outFire;
    // The input lands in skid whenever main cannot take it directly: main is
    // stalled, or main is being refilled from skid in the same cycle.
    assign loadSkid = inFire && (!mainFree || skidValid);

    assign inReady  = !skidValid;
    assign outValid = mainValid;
    assign outData  = mainData;

    // Occupancy and main-entry payload; skid drains into main ahead of new input.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
        if (!rst_n) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainData  <= '0;
        end else begin
            if (mainFree) begin
                if (skidValid) begin
                    mainValid <= 1'b1;
                    mainData  <= skidData;
                    skidValid <= inFire;
                end else if (inFire) begin
                    mainValid <= 1'b1;
                    mainData  <= inData;
                end else begin
                    mainValid <= 1'b0;
                end
            end else if (inFire) begin
                skidValid <= 1'b1;
            end
        end
    end

    // Skid payload capture.
    always_ff @(posedge clk) begin
        // NOTE: skid payload is deliberately not reset; skidValid alone qualifies it.
        if (loadSkid) begin
            skidData <= inData;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the logic and add/sub units. Selects the
// result for the issued opcode class, derives status flags from that
// selected value, and hands the record to the consumer through a 2-entry
// skid buffer. result_count tallies output handshakes and wraps silently.
// WIDTH and OP_W must match the record layout fixed in alu_pkg.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] logic_res,
    input  logic [WIDTH-1:0] arith_res,
    input  logic             arith_cout,
    input  logic             arith_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err,
    output logic [CNT_W-1:0] result_count
);

    alu_res_t   issued;
    alu_res_t   presented;
    res_flags_t flags;

    // Class select and flag generation for the incoming opcode.
    always_comb begin
        // NOTE: defaults first so every path assigns every field and no latch is inferred.
        issued     = '0;
        issued.op  = alu_op;
        case (alu_op[3:2])
            CLS_LOGIC: begin
                issued.result = logic_res;
            end
            CLS_ARITH: begin
                issued.result = arith_res;
                issued.carry  = arith_cout;
                issued.ovf    = arith_ovf;
            end
            default: begin
                issued.err = 1'b1;
            end
        endcase
        // Flags come from the selected value, so an illegal op reads zero=1, neg=0.
        flags       = calcFlags(issued.result);
        issued.zero = flags.zero;
        issued.neg  = flags.neg;
    end

    alu_skid_buf #(
        .PAYLOAD_W($bits(alu_res_t))
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .inValid (in_valid),
        .inReady (in_ready),
        .inData  (issued),
        .outValid(out_valid),
        .outReady(out_ready),
        .outData (presented)
    );

    assign out_result = presented.result;
    assign out_op     = presented.op;
    assign out_zero   = presented.zero;
    assign out_neg    = presented.neg;
    assign out_carry  = presented.carry;
    assign out_ovf    = presented.ovf;
    assign out_err    = presented.err;

    // Completed-result counter: one step per output handshake, wraps to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_count <= '0;
        end else if (out_valid && out_ready) begin
            result_count <= result_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: a scoreboard queue is filled on every input
// handshake from an independent class/flag model and drained on every
// output handshake; scenario tasks add their own directed checks.
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int OP_W  = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OP_W-1:0]  alu_op = '0;
    logic [WIDTH-1:0] logic_res = '0;
    logic [WIDTH-1:0] arith_res = '0;
    logic             arith_cout = 1'b0;
    logic             arith_ovf = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [OP_W-1:0]  out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_ovf;
    logic             out_err;
    logic [CNT_W-1:0] result_count;

    alu_result_stage #(
        .WIDTH(WIDTH),
        .OP_W (OP_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .logic_res   (logic_res),
        .arith_res   (arith_res),
        .arith_cout  (arith_cout),
        .arith_ovf   (arith_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_carry   (out_carry),
        .out_ovf     (out_ovf),
        .out_err     (out_err),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [OP_W-1:0]  op;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;
    int   nComp = 0;
    int   nFail = 0;
    int   expCount = 0;

    function automatic exp_t model(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] lr,
                                   input logic [WIDTH-1:0] ar, input logic co, input logic ov);
        exp_t e;
        e.op = op; e.carry = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
        if (op[3:2] == 2'b00) begin
            e.res = lr;
        end else if (op[3:2] == 2'b01) begin
            e.res = ar; e.carry = co; e.ovf = ov;
        end else begin
            e.res = '0; e.err = 1'b1;
        end
        e.zero = (e.res == 0);
        e.neg  = e.res[WIDTH-1];
        return e;
    endfunction

    // Scoreboard monitor: pop/compare on output handshake, push on input handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                nComp++;
                if (sb.size() == 0) begin
                    nFail++;
                    $display("FAIL unexpected_output: got res=%h op=%h, required no output", out_result, out_op);
                end else begin
                    monExp = sb.pop_front();
                    if ({out_result, out_op, out_zero, out_neg, out_carry, out_ovf, out_err} !==
                        {monExp.res, monExp.op, monExp.zero, monExp.neg, monExp.carry, monExp.ovf, monExp.err}) begin
                        nFail++;
                        $display("FAIL out_payload: got res=%h op=%h z=%b n=%b c=%b v=%b e=%b, required res=%h op=%h z=%b n=%b c=%b v=%b e=%b",
                                 out_result, out_op, out_zero, out_neg, out_carry, out_ovf, out_err,
                                 monExp.res, monExp.op, monExp.zero, monExp.neg, monExp.carry, monExp.ovf, monExp.err);
                    end
                end
                nComp++;
                if (result_count !== expCount[CNT_W-1:0]) begin
                    nFail++;
                    $display("FAIL result_count_at_handshake: got %0d, required %0d", result_count, expCount[CNT_W-1:0]);
                end
                expCount = (expCount + 1) % (1 << CNT_W);
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb.push_back(model(alu_op, logic_res, arith_res, arith_cout, arith_ovf));
            end
        end
    end

    // Present one input and hold it until accepted; returns cycles spent.
    task automatic drive(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] lr, input logic [WIDTH-1:0] ar,
                         input logic co, input logic ov, output int waited);
        bit fired = 1'b0;
        in_valid = 1'b1; alu_op = op; logic_res = lr; arith_res = ar; arith_cout = co; arith_ovf = ov;
        waited = 0;
        while (!fired && waited < 50) begin
            @(negedge clk);
            fired = (in_ready === 1'b1);
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!fired) begin
            nComp++; nFail++;
            $display("FAIL drive_timeout: got in_ready stuck low for %0d cycles, required acceptance", waited);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete(); expCount = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid !== 1'b0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            nComp++; nFail++;
            $display("FAIL drain_timeout: got %0d entries pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; alu_op = 4'b0001; logic_res = 32'h0000_00AA; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nComp++;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        nComp++;
        if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        nComp++;
        if (result_count !== '0) begin nFail++; $display("FAIL reset_count: got %0d, required 0", result_count); end
        nComp++;
        if (out_result !== '0 || out_err !== 1'b0 || out_zero !== 1'b0) begin
            nFail++; $display("FAIL reset_outputs: got res=%h err=%b zero=%b, required all 0", out_result, out_err, out_zero);
        end
        @(posedge clk); #1;
        sb.delete(); expCount = 0;
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        nComp++;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_no_spurious: got out_valid=%b, required 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_logic_op();
        int w;
        out_ready = 1'b1;
        drive(4'b0001, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, w);
        @(negedge clk);
        nComp++;
        if (out_valid !== 1'b1 || out_result !== 32'h0) begin
            nFail++; $display("FAIL logic_result: got valid=%b res=%h, required valid=1 res=0", out_valid, out_result);
        end
        nComp++;
        if ({out_zero, out_neg, out_carry, out_ovf, out_err} !== 5'b10000) begin
            nFail++; $display("FAIL logic_flags: got zncve=%b, required 10000", {out_zero, out_neg, out_carry, out_ovf, out_err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arith_op();
        int w;
        out_ready = 1'b1;
        drive(4'b0100, 32'h0F0F_0000, 32'h8000_0000, 1'b1, 1'b1, w);
        @(negedge clk);
        nComp++;
        if (out_valid !== 1'b1 || out_result !== 32'h8000_0000) begin
            nFail++; $display("FAIL arith_result: got valid=%b res=%h, required valid=1 res=80000000", out_valid, out_result);
        end
        nComp++;
        if ({out_zero, out_neg, out_carry, out_ovf, out_err} !== 5'b01110) begin
            nFail++; $display("FAIL arith_flags: got zncve=%b, required 01110", {out_zero, out_neg, out_carry, out_ovf, out_err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_op();
        int w;
        out_ready = 1'b1;
        drive(4'b1011, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b1, w);
        @(negedge clk);
        nComp++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_op !== 4'b1011) begin
            nFail++; $display("FAIL illegal_result: got valid=%b res=%h op=%h, required valid=1 res=0 op=b", out_valid, out_result, out_op);
        end
        nComp++;
        if ({out_zero, out_neg, out_carry, out_ovf, out_err} !== 5'b10001) begin
            nFail++; $display("FAIL illegal_flags: got zncve=%b, required 10001", {out_zero, out_neg, out_carry, out_ovf, out_err});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        out_ready = 1'b0;
        fork
            begin
                int w;
                for (int v = 1; v <= 4; v++) drive(4'b0010, WIDTH'(v), '0, 1'b0, 1'b0, w);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                held = out_result;
                nComp++;
                if (out_valid !== 1'b1 || held !== 32'd1) begin
                    nFail++; $display("FAIL bp_first_out: got valid=%b res=%h, required valid=1 res=1", out_valid, held);
                end
                @(negedge clk);
                nComp++;
                if (in_ready !== 1'b0) begin nFail++; $display("FAIL bp_in_ready_drop: got %b, required 0", in_ready); end
                nComp++;
                if (out_result !== held) begin nFail++; $display("FAIL bp_stable_1: got %h, required %h", out_result, held); end
                @(negedge clk);
                nComp++;
                if (out_valid !== 1'b1 || out_result !== held) begin
                    nFail++; $display("FAIL bp_stable_2: got valid=%b res=%h, required valid=1 res=%h", out_valid, out_result, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_mid_transfer();
        int w;
        out_ready = 1'b0;
        drive(4'b0001, 32'h0000_0011, '0, 1'b0, 1'b0, w);
        drive(4'b0001, 32'h0000_0022, '0, 1'b0, 1'b0, w);
        do_reset();
        @(negedge clk);
        nComp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nFail++; $display("FAIL midreset_state: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        nComp++;
        if (out_valid !== 1'b0 || result_count !== '0) begin
            nFail++; $display("FAIL midreset_replay: got out_valid=%b count=%0d, required 0/0", out_valid, result_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                int w;
                for (int i = 0; i < 40; i++) begin
                    logic [OP_W-1:0] op = OP_W'($urandom_range(0, 15));
                    logic [WIDTH-1:0] lr = ($urandom_range(0, 3) == 0) ? '0 : $urandom();
                    logic [WIDTH-1:0] ar = ($urandom_range(0, 3) == 0) ? '0 : $urandom();
                    drive(op, lr, ar, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        wait_drain();
    endtask

    task automatic test_counter_wrap();
        int w;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(4'b0100, '0, WIDTH'(i * 3 + 1), 1'b0, 1'b0, w);
            nComp++;
            if (w !== 1) begin nFail++; $display("FAIL wrap_throughput: item %0d took %0d cycles, required 1", i, w); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        nComp++;
        if (result_count !== 4'd1 || out_valid !== 1'b0) begin
            nFail++; $display("FAIL wrap_count: got count=%0d valid=%b, required 1/0", result_count, out_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_logic_op();
        test_arith_op();
        test_illegal_op();
        test_backpressure();
        test_reset_mid_transfer();
        test_random();
        test_counter_wrap();
        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
